// File: rtl/pktgate_if.sv
// pktgate_if: byte-stream handshake bundle used on both sides of pktgate.
//   valid/ready : transfer handshake (a beat moves when both are high)
//   data[7:0]   : payload byte
//   last        : final byte of a packet
//   abort       : source abandons the packet in progress (slave side only;
//                 a master that has no abort concept drives it low)
// Modports:
//   master : drives valid/data/last/abort, samples ready
//   slave  : samples valid/data/last/abort, drives ready
interface pktgate_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;
    logic       abort;

    modport master (
        output valid,
        output data,
        output last,
        output abort,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        input  abort,
        output ready
    );
endinterface

// File: rtl/pktgate.sv
// pktgate: store-and-forward packet gate in front of a packet-mux input.
// Bytes are written into a circular buffer as they arrive. Only whole
// packets, committed when their LAST beat lands, are made visible to the
// reader, so the output never starts a packet it cannot finish. The source
// is never stalled. A packet that overflows the buffer or is aborted by the
// source is discarded by rewinding the write pointer to the last commit.
//
// Parameters:
//   LGFLEN       : log2 of the buffer depth in bytes
//   OPT_LOWPOWER : zero the output data/last whenever the output is idle
//
// Ports:
//   S_AXI_ACLK   : clock, all logic on its rising edge
//   S_AXI_ARESET : asynchronous active-high reset
//   s_axin       : incoming byte stream (S_AXIN_VALID/READY/DATA/LAST/ABORT)
//   m_axin       : outgoing whole-packet stream (M_AXIN_VALID/READY/DATA/LAST)
//   o_pkts       : committed packet count
//   o_drops      : dropped packet count
//
// Build option: define PKTGATE_STATS_EN to get saturating 16-bit packet and
// drop counters; without it o_pkts and o_drops are tied to zero.
module pktgate #(
    parameter int unsigned LGFLEN       = 11,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    pktgate_if.slave    s_axin,
    pktgate_if.master   m_axin,
    output logic [15:0] o_pkts,
    output logic [15:0] o_drops
);

    localparam int unsigned DEPTH = 1 << LGFLEN;
    localparam int unsigned AW    = LGFLEN + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [8:0]     mem [DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  wr_commit;
    logic [AW-1:0]  rd_addr;

    logic           s_ready;
    logic           m_valid;
    logic [7:0]     m_data;
    logic           m_last;

    logic           accept_c;
    logic           full_c;
    logic           wr_en_c;
    logic           commit_c;
    logic           rewind_c;
    logic           rd_load_c;
    logic           rd_avail_c;

    assign accept_c   = s_axin.valid && s_ready;
    assign full_c     = ((wr_addr - rd_addr) == AW'(DEPTH));
    assign rd_load_c  = !m_valid || m_axin.ready;
    assign rd_avail_c = (rd_addr != wr_commit);

    // Input FSM state register.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Input FSM next-state logic; abort takes priority over a same-cycle beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!s_axin.abort && accept_c && !s_axin.last) begin
                    state_nxt = full_c ? DROP : FILL;
                end
            end
            FILL: begin
                if (s_axin.abort) begin
                    state_nxt = IDLE;
                end else if (accept_c) begin
                    if (s_axin.last) begin
                        state_nxt = IDLE;
                    end else if (full_c) begin
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (s_axin.abort || (accept_c && s_axin.last)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Input FSM outputs: write, commit on LAST, or rewind (one dropped packet).
    // An abort arriving with a first beat in IDLE discards that beat as a
    // one-beat dropped packet; the rewind itself is a no-op there.
    always_comb begin
        wr_en_c  = 1'b0;
        commit_c = 1'b0;
        rewind_c = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (s_axin.abort) begin
                    if ((state == FILL) || accept_c) begin
                        rewind_c = 1'b1;
                    end
                end else if (accept_c) begin
                    if (full_c) begin
                        rewind_c = 1'b1;
                    end else begin
                        wr_en_c  = 1'b1;
                        commit_c = s_axin.last;
                    end
                end
            end
            default: begin
                wr_en_c  = 1'b0;
            end
        endcase
    end

    // Packet storage, {LAST, DATA}; contents are never reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_en_c) begin
            mem[wr_addr[LGFLEN-1:0]] <= {s_axin.last, s_axin.data};
        end
    end

    // Write and commit pointers.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_addr   <= '0;
            wr_commit <= '0;
        end else if (rewind_c) begin
            wr_addr   <= wr_commit;
        end else if (wr_en_c) begin
            wr_addr <= wr_addr + AW'(1);
            if (commit_c) begin
                wr_commit <= wr_addr + AW'(1);
            end
        end
    end

    // Source is never back-pressured outside reset.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= 1'b1;
        end
    end

    // Output register: reads only committed bytes, holds while stalled.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rd_addr <= '0;
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            m_last  <= 1'b0;
        end else if (rd_load_c) begin
            if (rd_avail_c) begin
                m_valid          <= 1'b1;
                {m_last, m_data} <= mem[rd_addr[LGFLEN-1:0]];
                rd_addr          <= rd_addr + AW'(1);
            end else begin
                m_valid <= 1'b0;
                if (OPT_LOWPOWER) begin
                    m_data <= 8'd0;
                    m_last <= 1'b0;
                end
            end
        end
    end

    assign s_axin.ready = s_ready;
    assign m_axin.valid = m_valid;
    assign m_axin.data  = m_data;
    assign m_axin.last  = m_last;
    assign m_axin.abort = 1'b0;

`ifdef PKTGATE_STATS_EN
    logic [15:0] pkts_q;
    logic [15:0] drops_q;

    // Saturating commit and drop counters.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            pkts_q  <= 16'd0;
            drops_q <= 16'd0;
        end else begin
            if (commit_c && (pkts_q != 16'hFFFF)) begin
                pkts_q <= pkts_q + 16'd1;
            end
            if (rewind_c && (drops_q != 16'hFFFF)) begin
                drops_q <= drops_q + 16'd1;
            end
        end
    end

    assign o_pkts  = pkts_q;
    assign o_drops = drops_q;
`else
    assign o_pkts  = 16'd0;
    assign o_drops = 16'd0;
`endif

endmodule

// File: tb/tb_pktgate.sv
// tb_pktgate: directed self-checking bench for pktgate (LGFLEN=4, low-power
// output zeroing enabled). Inputs change 2 time units after the rising edge;
// a monitor records every output transfer on the falling edge.
module tb_pktgate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] o_pkts;
    logic [15:0] o_drops;

    pktgate_if s_if ();
    pktgate_if m_if ();

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int last_beat_cyc = 0;

    logic [8:0] got_q[$];
    int         got_cyc[$];

    pktgate #(
        .LGFLEN       (4),
        .OPT_LOWPOWER (1'b1)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axin       (s_if),
        .m_axin       (m_if),
        .o_pkts       (o_pkts),
        .o_drops      (o_drops)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_if.valid && m_if.ready) begin
            got_q.push_back({m_if.last, m_if.data});
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef PKTGATE_STATS_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [8:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 9'bx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        s_if.valid = 1'b0;
        s_if.data  = 8'd0;
        s_if.last  = 1'b0;
        s_if.abort = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_in();
        m_if.ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic send_pkt(input logic [7:0] base, input logic [7:0] step,
                            input int n, input int abort_at);
        for (int i = 0; i < n; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = 8'(base + step * 8'(i));
            s_if.last  = (i == n - 1);
            s_if.abort = (i == abort_at);
            last_beat_cyc = cyc;
            tick();
            if (i == abort_at) break;
        end
        idle_in();
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while ((got_q.size() < n) && (b > 0)) begin
            tick();
            b--;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        m_if.ready = 1'b0;
        idle_in();
        #1 rst = 1'b1;
        repeat (2) tick();
        vectors++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_if.valid); end
        vectors++; if (m_if.data !== 8'd0) begin errors++; $display("FAIL reset_data: got %h want 00", m_if.data); end
        vectors++; if (m_if.last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_if.last); end
        vectors++; if (s_if.ready !== 1'b0) begin errors++; $display("FAIL reset_sready: got %b want 0", s_if.ready); end
        vectors++; if (o_pkts !== 16'd0) begin errors++; $display("FAIL reset_pkts: got %0d want 0", o_pkts); end
        vectors++; if (o_drops !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d want 0", o_drops); end
        rst = 1'b0;
        tick();
        vectors++; if (s_if.ready !== 1'b1) begin errors++; $display("FAIL post_reset_sready: got %b want 1", s_if.ready); end
        vectors++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", m_if.valid); end
    endtask

    task automatic test_basic();
        logic [8:0] exp [4];
        bit ok;
        exp = '{9'h011, 9'h022, 9'h033, 9'h144};
        apply_reset();
        send_pkt(8'h11, 8'h11, 4, -1);
        wait_out(4, 20, ok);
        repeat (4) tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: got %0d beats want 4", got_q.size()); end
        vectors++; if (got_q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_at(i) !== exp[i]) begin errors++; $display("FAIL basic_beat[%0d]: got %h want %h", i, got_at(i), exp[i]); end
        end
        if (got_cyc.size() >= 4) begin
            vectors++;
            if (got_cyc[0] !== last_beat_cyc + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", got_cyc[0] - last_beat_cyc, 2); end
            vectors++;
            if (got_cyc[3] - got_cyc[0] !== 3) begin errors++; $display("FAIL basic_consecutive: got span %0d want 3", got_cyc[3] - got_cyc[0]); end
        end
        vectors++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b want 0", m_if.valid); end
        vectors++; if (m_if.data !== 8'd0) begin errors++; $display("FAIL basic_lowpower_data: got %h want 00", m_if.data); end
        vectors++; if (o_pkts !== exp_cnt(1)) begin errors++; $display("FAIL basic_pkts: got %0d want %0d", o_pkts, exp_cnt(1)); end
        vectors++; if (o_drops !== exp_cnt(0)) begin errors++; $display("FAIL basic_drops: got %0d want %0d", o_drops, exp_cnt(0)); end
    endtask

    task automatic test_abort();
        bit ok;
        apply_reset();
        send_pkt(8'h01, 8'h01, 10, 2);
        repeat (4) tick();
        vectors++; if (got_q.size() !== 0) begin errors++; $display("FAIL abort_leak: got %0d beats want 0", got_q.size()); end
        send_pkt(8'hAA, 8'h11, 2, -1);
        wait_out(2, 20, ok);
        repeat (4) tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_timeout: got %0d beats want 2", got_q.size()); end
        vectors++; if (got_q.size() !== 2) begin errors++; $display("FAIL abort_count: got %0d want 2", got_q.size()); end
        vectors++; if (got_at(0) !== 9'h0AA) begin errors++; $display("FAIL abort_beat0: got %h want 0aa", got_at(0)); end
        vectors++; if (got_at(1) !== 9'h1BB) begin errors++; $display("FAIL abort_beat1: got %h want 1bb", got_at(1)); end
        vectors++; if (o_drops !== exp_cnt(1)) begin errors++; $display("FAIL abort_drops: got %0d want %0d", o_drops, exp_cnt(1)); end
        vectors++; if (o_pkts !== exp_cnt(1)) begin errors++; $display("FAIL abort_pkts: got %0d want %0d", o_pkts, exp_cnt(1)); end
    endtask

    task automatic test_full();
        bit ok;
        logic [8:0] e;
        apply_reset();
        m_if.ready = 1'b0;
        send_pkt(8'h40, 8'h01, 16, -1);
        repeat (3) tick();
        vectors++; if (m_if.valid !== 1'b1) begin errors++; $display("FAIL full_hold_valid: got %b want 1", m_if.valid); end
        vectors++; if (m_if.data !== 8'h40) begin errors++; $display("FAIL full_hold_data: got %h want 40", m_if.data); end
        send_pkt(8'h60, 8'h01, 5, -1);
        repeat (3) tick();
        vectors++; if ({m_if.last, m_if.data} !== 9'h040) begin errors++; $display("FAIL full_stall_stable: got %h want 040", {m_if.last, m_if.data}); end
        vectors++; if (o_drops !== exp_cnt(1)) begin errors++; $display("FAIL full_drops: got %0d want %0d", o_drops, exp_cnt(1)); end
        vectors++; if (o_pkts !== exp_cnt(1)) begin errors++; $display("FAIL full_pkts: got %0d want %0d", o_pkts, exp_cnt(1)); end
        m_if.ready = 1'b1;
        wait_out(16, 60, ok);
        repeat (6) tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout: got %0d beats want 16", got_q.size()); end
        vectors++; if (got_q.size() !== 16) begin errors++; $display("FAIL full_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            e = {(i == 15), 8'(8'h40 + i)};
            vectors++;
            if (got_at(i) !== e) begin errors++; $display("FAIL full_beat[%0d]: got %h want %h", i, got_at(i), e); end
        end
    endtask

    task automatic test_long();
        bit ok;
        apply_reset();
        send_pkt(8'h00, 8'h01, 40, -1);
        send_pkt(8'hD0, 8'h01, 3, -1);
        wait_out(3, 40, ok);
        repeat (4) tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL long_timeout: got %0d beats want 3", got_q.size()); end
        vectors++; if (got_q.size() !== 3) begin errors++; $display("FAIL long_count: got %0d want 3", got_q.size()); end
        vectors++; if (got_at(0) !== 9'h0D0) begin errors++; $display("FAIL long_beat0: got %h want 0d0", got_at(0)); end
        vectors++; if (got_at(1) !== 9'h0D1) begin errors++; $display("FAIL long_beat1: got %h want 0d1", got_at(1)); end
        vectors++; if (got_at(2) !== 9'h1D2) begin errors++; $display("FAIL long_beat2: got %h want 1d2", got_at(2)); end
        vectors++; if (o_drops !== exp_cnt(1)) begin errors++; $display("FAIL long_drops: got %0d want %0d", o_drops, exp_cnt(1)); end
        vectors++; if (o_pkts !== exp_cnt(1)) begin errors++; $display("FAIL long_pkts: got %0d want %0d", o_pkts, exp_cnt(1)); end
    endtask

    task automatic test_stall();
        logic [31:0] pat;
        logic        p_v;
        logic        p_r;
        logic [8:0]  p_d;
        logic [8:0]  e;
        bit          ok;
        pat = 32'b1011_0010_0110_1100_1001_1101_0011_0101;
        apply_reset();
        send_pkt(8'h80, 8'h01, 8, -1);
        for (int i = 0; i < 32; i++) begin
            m_if.ready = pat[i];
            p_v = m_if.valid;
            p_r = pat[i];
            p_d = {m_if.last, m_if.data};
            tick();
            if (p_v && !p_r) begin
                vectors++;
                if ((m_if.valid !== 1'b1) || ({m_if.last, m_if.data} !== p_d)) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", i, m_if.valid, {m_if.last, m_if.data}, p_d);
                end
            end
        end
        m_if.ready = 1'b1;
        wait_out(8, 30, ok);
        repeat (4) tick();
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: got %0d beats want 8", got_q.size()); end
        vectors++; if (got_q.size() !== 8) begin errors++; $display("FAIL stall_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            e = {(i == 7), 8'(8'h80 + i)};
            vectors++;
            if (got_at(i) !== e) begin errors++; $display("FAIL stall_beat[%0d]: got %h want %h", i, got_at(i), e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        send_pkt(8'h20, 8'h01, 12, -1);
        wait_out(3, 20, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_start: got %0d beats want 3", got_q.size()); end
        rst = 1'b1;
        #1;
        vectors++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", m_if.valid); end
        vectors++; if (s_if.ready !== 1'b0) begin errors++; $display("FAIL rstmid_sready: got %b want 0", s_if.ready); end
        vectors++; if (o_pkts !== 16'd0) begin errors++; $display("FAIL rstmid_pkts: got %0d want 0", o_pkts); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        got_q.delete();
        got_cyc.delete();
        repeat (4) tick();
        vectors++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_flushed: got %0d beats want 0", got_q.size()); end
        send_pkt(8'hC1, 8'h01, 3, -1);
        wait_out(3, 20, ok);
        repeat (4) tick();
        vectors++; if (got_q.size() !== 3) begin errors++; $display("FAIL rstmid_count: got %0d want 3", got_q.size()); end
        vectors++; if (got_at(0) !== 9'h0C1) begin errors++; $display("FAIL rstmid_beat0: got %h want 0c1", got_at(0)); end
        vectors++; if (got_at(1) !== 9'h0C2) begin errors++; $display("FAIL rstmid_beat1: got %h want 0c2", got_at(1)); end
        vectors++; if (got_at(2) !== 9'h1C3) begin errors++; $display("FAIL rstmid_beat2: got %h want 1c3", got_at(2)); end
        vectors++; if (o_pkts !== exp_cnt(1)) begin errors++; $display("FAIL rstmid_pkts_after: got %0d want %0d", o_pkts, exp_cnt(1)); end
        vectors++; if (o_drops !== exp_cnt(0)) begin errors++; $display("FAIL rstmid_drops_after: got %0d want %0d", o_drops, exp_cnt(0)); end
    endtask

    initial begin
        idle_in();
        m_if.ready = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_full();
        test_long();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pktgate.md
PKTGATE -- requirements
Module: pktgate

Interface
REQ-001 SHALL have parameter LGFLEN, default 11; log2 of buffer depth in bytes (2048).
REQ-002 SHALL have parameter OPT_LOWPOWER, default 1'b0; when set, M_AXIN_DATA and M_AXIN_LAST are zeroed whenever M_AXIN_VALID is low.
REQ-003 SHALL have port S_AXI_ACLK  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port S_AXI_ARESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports S_AXIN_VALID  input  1, S_AXIN_READY  output  1, S_AXIN_DATA  input  8, S_AXIN_LAST  input  1; the incoming byte stream.
REQ-006 SHALL have port S_AXIN_ABORT  input  1  source-declared abort of the packet in progress.
REQ-007 SHALL have ports M_AXIN_VALID  output  1, M_AXIN_READY  input  1, M_AXIN_DATA  output  8, M_AXIN_LAST  output  1; whole-packet stream feeding one packet-mux input.
REQ-008 SHALL have ports o_pkts  output  16 (committed packets) and o_drops  output  16 (dropped packets).

Function
REQ-009 Storage SHALL be a 2^LGFLEN x 9-bit memory {LAST, DATA}, with write pointer wr_addr, committed pointer wr_commit and read pointer rd_addr, each LGFLEN+1 bits wide and wrapping modulo 2^(LGFLEN+1).
REQ-010 S_AXIN_READY SHALL be 1 in every non-reset cycle; the block never stalls its source, and loss occurs only by dropping packets.
REQ-011 The input FSM SHALL have the states IDLE (between packets), FILL (packet being written) and DROP (discarding the rest of a packet).
REQ-012 Buffer full SHALL mean (wr_addr - rd_addr) == 2^LGFLEN.
REQ-013 In IDLE or FILL, an accepted beat while not full SHALL write {LAST, DATA} at wr_addr and increment wr_addr.
REQ-014 An accepted beat with LAST and no overflow SHALL set wr_commit to the incremented wr_addr on the same clock edge and move the FSM to IDLE; a single-beat packet SHALL commit directly from IDLE.
REQ-015 An accepted beat without LAST in IDLE SHALL move the FSM to FILL.
REQ-016 An accepted beat while full SHALL rewind wr_addr to wr_commit and increment the drop count.
REQ-017 That overflow beat SHALL move the FSM to DROP if it lacks LAST, else to IDLE.
REQ-018 In DROP, beats SHALL be discarded without writing; an accepted LAST SHALL return the FSM to IDLE.
REQ-019 S_AXIN_ABORT high in FILL SHALL rewind wr_addr to wr_commit, increment the drop count and move the FSM to IDLE.
REQ-020 S_AXIN_ABORT in DROP SHALL return the FSM to IDLE with no second drop count.
REQ-021 S_AXIN_ABORT in IDLE with no accepted beat SHALL be ignored.
REQ-022 If S_AXIN_ABORT and an accepted beat occur in the same cycle, abort SHALL win: the beat is not written and any partial packet is dropped and counted once.
REQ-023 Output SHALL load when (!M_AXIN_VALID || M_AXIN_READY) and rd_addr != wr_commit: M_AXIN_DATA/LAST <= mem[rd_addr], M_AXIN_VALID <= 1, rd_addr increments.
REQ-024 When (!M_AXIN_VALID || M_AXIN_READY) and rd_addr == wr_commit, M_AXIN_VALID SHALL drop to 0.
REQ-025 Only committed bytes SHALL ever be read, so once M_AXIN_VALID rises it stays high through M_AXIN_LAST whenever M_AXIN_READY stays high.
REQ-026 Minimum latency SHALL be: LAST accepted at edge N -> wr_commit updated at edge N -> M_AXIN_VALID high after edge N+1.
REQ-027 While M_AXIN_VALID && !M_AXIN_READY, M_AXIN_DATA and M_AXIN_LAST SHALL hold stable.
REQ-028 A packet longer than 2^LGFLEN bytes SHALL always be dropped and SHALL never deadlock the block.

Reset
REQ-029 S_AXI_ARESET SHALL asynchronously clear wr_addr, wr_commit, rd_addr, the FSM (to IDLE), M_AXIN_VALID, M_AXIN_DATA, M_AXIN_LAST, o_pkts, o_drops and S_AXIN_READY.
REQ-030 Reset mid-packet SHALL discard all buffered data, committed or not; memory contents need no reset.

Configuration
REQ-031 With macro PKTGATE_STATS_EN defined, o_pkts SHALL count commits and o_drops SHALL count drops, each 16-bit and saturating at 16'hFFFF.
REQ-032 Without PKTGATE_STATS_EN, o_pkts and o_drops SHALL be tied to 0 and the counters SHALL not be synthesized; all other behaviour is identical.

Verification
REQ-033 Bench SHALL send a 4-byte packet 11,22,33,44 (LAST on 44) with READY=1 -> output 11,22,33,44 on consecutive cycles with LAST on 44; VALID rises 2 cycles after the 44 beat; o_pkts=1.
REQ-034 Bench SHALL send ABORT on byte 3 of a 10-byte packet, then a 2-byte packet AA,BB -> output only AA,BB; o_drops=1, o_pkts=1.
REQ-035 With LGFLEN=4, M_AXIN_READY=0 and a committed 16-byte packet held, bench SHALL send a 5-byte packet -> it is dropped (o_drops=1); after READY=1, only the 16-byte packet appears.
REQ-036 With LGFLEN=4, bench SHALL send a 40-byte packet then a 3-byte packet -> 40-byte dropped, 3-byte delivered intact; no hang.
REQ-037 Bench SHALL toggle M_AXIN_READY mid-packet -> DATA/LAST stable while stalled; no byte lost or duplicated.
REQ-038 Bench SHALL assert S_AXI_ARESET mid-output -> M_AXIN_VALID=0 immediately; a subsequent new packet is delivered correctly with counters restarted from 0.
